microprocessor_led_arbiter: RTL

Shares the 8-bit LED output PIO slave between NUM_REQ on-chip requesters, such as the CPU bridge, a heartbeat generator and a fault indicator. It arbitrates round-robin and issues single-cycle Avalon-MM writes to the PIO data register at offset 0. After each write it holds ownership for a configurable number of cycles so that a pattern stays visible. It keeps a shadow copy of the last value written.

---
 rtl/microprocessor_led_arb_pkg.sv | 14 +
 rtl/microprocessor_rr_picker.sv | 32 +++
 rtl/microprocessor_led_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/microprocessor_led_arb_pkg.sv
// Shared types and constants for the LED PIO arbiter.
// Used by the top level and the round-robin picker.
package microprocessor_led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] LED_DATA_ADDR = 2'd0;
  localparam int PIO_DATA_WIDTH = 32;

endpackage

// File: rtl/microprocessor_rr_picker.sv
// Combinational round-robin picker: first asserted
// request at or after the pointer, wrapping upward.
module microprocessor_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      winner
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from the far end so the closest hit wins last.
  always_comb begin
    valid  = |req;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (req[idx])
        winner = idx;
    end
  end

endmodule

// File: rtl/microprocessor_led_arbiter.sv
// Round-robin owner of the LED PIO: one write per
// grant, then a hold window so the pattern stays lit.
module microprocessor_led_arbiter
  import microprocessor_led_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int HOLD_CYCLES = 16,
  parameter  int LED_WIDTH   = 8,
  localparam int PW          = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LED_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [1:0]                   pio_address,
  output logic                         pio_chipselect,
  output logic                         pio_write_n,
  output logic [PIO_DATA_WIDTH-1:0]    pio_writedata,
  output logic [LED_WIDTH-1:0]         led_shadow,
  output logic                         busy
);

  localparam int CW =
    (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam int PAD = PIO_DATA_WIDTH - LED_WIDTH;

  state_t                    state;
  state_t                    state_nx;
  logic [PW-1:0]             ptr;
  logic [PW-1:0]             win;
  logic [CW-1:0]             cnt;
  logic                      pick_valid;
  logic [PW-1:0]             pick_win;
  logic [LED_WIDTH-1:0]      pick_data;
  logic [NUM_REQ-1:0]        ack_nx;
  logic                      cs_nx;
  logic [PIO_DATA_WIDTH-1:0] wd_nx;
  logic                      busy_nx;

  microprocessor_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_win == PW'(i))
        pick_data = req_data[i*LED_WIDTH +: LED_WIDTH];
  end

  assign pio_address = LED_DATA_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      win            <= '0;
      cnt            <= '0;
      led_shadow     <= '0;
      ack            <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      ack            <= ack_nx;
      pio_chipselect <= cs_nx;
      pio_write_n    <= ~cs_nx;
      pio_writedata  <= wd_nx;
      busy           <= busy_nx;
      if (state == IDLE && pick_valid)
        win <= pick_win;
      if (state == WRITE) begin
        led_shadow <= pio_writedata[LED_WIDTH-1:0];
        ptr        <= (win == LAST) ? '0
                                    : win + PW'(1);
        cnt        <= HOLD_LOAD;
      end
      if (state == HOLD && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nx = WRITE;
      WRITE:   state_nx = (HOLD_CYCLES > 0) ? HOLD
                                            : IDLE;
      HOLD:    if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed one cycle early and registered.
  always_comb begin
    ack_nx  = '0;
    cs_nx   = 1'b0;
    wd_nx   = '0;
    busy_nx = (state_nx != IDLE);
    if (state_nx == WRITE) begin
      ack_nx[pick_win] = 1'b1;
      cs_nx            = 1'b1;
      wd_nx            = {{PAD{1'b0}}, pick_data};
    end
  end

endmodule
